// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module hazard_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch
// and multi-cycle data-memory hazards, with perf counters and timeout error.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_MemRead,
  input  logic [4:0]       ex_WriteReg,
  input  logic             mem_Branch,
  input  logic             mem_zero,
  input  logic             mem_MemRead,
  input  logic             mem_MemWrite,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [15:0] TIMEOUT_W = 16'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_nxt;
  logic        r_mem_err;

  logic w_memop;
  logic w_taken;
  logic w_lu;
  logic w_mem_stall;
  logic w_release;
  logic w_timeout;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_memop = mem_MemRead | mem_MemWrite;
  assign w_taken = mem_Branch & mem_zero;
  assign w_lu    = ex_MemRead & (ex_WriteReg != REG_ZERO) &
                   ((ex_WriteReg == id_rs) | (ex_WriteReg == id_rt));

  // w_mem_stall: memory access outstanding this cycle; w_release: stages advance
  always_comb begin
    w_mem_stall = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      RUN: begin
        w_mem_stall = w_memop & ~dmem_ready;
        w_release   = ~(w_memop & ~dmem_ready);
      end
      MEM_WAIT: begin
        w_mem_stall = ~dmem_ready;
        w_release   = dmem_ready;
      end
      default: ;
    endcase
  end

  assign w_timeout   = (r_state == MEM_WAIT) & ~dmem_ready & (r_wait_cnt >= TIMEOUT_W);
  assign w_stall_inc = w_mem_stall | (w_release & ~w_taken & w_lu);
  assign w_flush_inc = w_release & w_taken;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_mem_err  <= r_mem_err | w_timeout;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = MEM_WAIT;
          w_wait_nxt  = 16'd1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          w_state_nxt = RUN;
          w_wait_nxt  = '0;
        end else if (w_timeout) begin
          w_state_nxt = HALT;
        end else begin
          w_wait_nxt = r_wait_cnt + 16'd1;
        end
      end
      HALT: ;
      default: w_state_nxt = RUN;
    endcase
  end

  // Reset overrides the state decode so dmem_req drops and bubbles load immediately
  always_comb begin
    dmem_req      = 1'b0;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    if (!RESET_N) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (w_mem_stall) begin
      dmem_req    = 1'b1;
      memwb_en    = 1'b1;
      memwb_flush = 1'b1;
    end else if (w_release) begin
      dmem_req = w_memop | (r_state == MEM_WAIT);
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      idex_en  = 1'b1;
      if (w_taken) begin
        pc_sel_branch = 1'b1;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        exmem_flush   = 1'b1;
      end else if (w_lu) begin
        idex_flush = 1'b1;
      end else begin
        pc_en   = 1'b1;
        ifid_en = 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;

  hazard_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .i_inc (w_stall_inc),
    .o_cnt (stall_cnt)
  );

  hazard_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .i_inc (w_flush_inc),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + randomized bench for pipeline_hazard_ctrl against a rule-level model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned T   = 4;
  localparam int unsigned CW  = 4;
  localparam int          SAT = 15;

  // {dmem_req, pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_f, idex_f, exmem_f, memwb_f}
  localparam logic [10:0] V_RESET  = 11'b0_0_0_0000_1111;
  localparam logic [10:0] V_STALL  = 11'b1_0_0_0001_0001;
  localparam logic [10:0] V_BRANCH = 11'b0_1_1_1111_1110;
  localparam logic [10:0] V_LU     = 11'b0_0_0_0111_0100;
  localparam logic [10:0] V_RUN    = 11'b0_1_0_1111_0000;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [4:0]    id_rs, id_rt, ex_WriteReg;
  logic          ex_MemRead, mem_Branch, mem_zero, mem_MemRead, mem_MemWrite, dmem_ready;
  logic          dmem_req, pc_en, pc_sel_branch;
  logic          ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic          mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [10:0]   obs;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .id_rs(id_rs), .id_rt(id_rt), .ex_MemRead(ex_MemRead), .ex_WriteReg(ex_WriteReg),
    .mem_Branch(mem_Branch), .mem_zero(mem_zero), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
    .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  assign obs = {dmem_req, pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: waiting flag, cycles spent waiting, halt/error, counter values
  bit m_wait, m_halt, m_err;
  int m_wcyc, m_stall, m_flush;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  function automatic bit f_memop();
    return (mem_MemRead || mem_MemWrite);
  endfunction

  function automatic bit f_taken();
    return (mem_Branch && mem_zero);
  endfunction

  function automatic bit f_lu();
    return ex_MemRead && (ex_WriteReg != 0) && (ex_WriteReg == id_rs || ex_WriteReg == id_rt);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic logic [10:0] model_outputs();
    logic [10:0] e;
    bit stalled;
    stalled = !dmem_ready && (m_wait || f_memop());
    if (m_halt)         e = '0;
    else if (stalled)   e = V_STALL;
    else if (f_taken()) e = V_BRANCH;
    else if (f_lu())    e = V_LU;
    else                e = V_RUN;
    if (!m_halt && !stalled) e[10] = f_memop() || m_wait;
    return e;
  endfunction

  task automatic model_advance();
    if (m_halt) return;
    if (!dmem_ready && (m_wait || f_memop())) begin
      m_stall = sat_inc(m_stall);
      if (!m_wait) begin
        m_wait = 1'b1;
        m_wcyc = 0;
      end else begin
        m_wcyc++;
        if (m_wcyc == int'(T)) begin
          m_halt = 1'b1;
          m_err  = 1'b1;
          m_wait = 1'b0;
        end
      end
    end else begin
      m_wait = 1'b0;
      if (f_taken())   m_flush = sat_inc(m_flush);
      else if (f_lu()) m_stall = sat_inc(m_stall);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_halt = 0; m_err = 0; m_wcyc = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input string tag);
    @(negedge CLK);
    check({tag, "/ctl"},   32'(obs),       32'(model_outputs()));
    check({tag, "/stall"}, 32'(stall_cnt), 32'(m_stall));
    check({tag, "/flush"}, 32'(flush_cnt), 32'(m_flush));
    check({tag, "/err"},   32'(mem_err),   32'(m_err));
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic exr,
                        input logic [4:0] exw, input logic br, input logic z,
                        input logic mr, input logic mw, input logic rdy);
    id_rs = rs; id_rt = rt; ex_MemRead = exr; ex_WriteReg = exw;
    mem_Branch = br; mem_zero = z; mem_MemRead = mr; mem_MemWrite = mw; dmem_ready = rdy;
  endtask

  // Called away from the clock edge; checks the asynchronous reset response
  task automatic do_reset(input string tag);
    RESET_N = 1'b0;
    #1;
    check({tag, "/rst_ctl"},   32'(obs),       32'(V_RESET));
    check({tag, "/rst_stall"}, 32'(stall_cnt), 32'd0);
    check({tag, "/rst_flush"}, 32'(flush_cnt), 32'd0);
    check({tag, "/rst_err"},   32'(mem_err),   32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset("init");

    set_in(5'd8, 5'd3, 1, 5'd8, 0, 0, 0, 0, 1);
    step("lu");
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    set_in(5'd8, 5'd3, 0, 5'd8, 0, 0, 0, 0, 1);
    step("lu_next");

    set_in(5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0, 1);
    step("zero_load");
    check("zero_stall_cnt", 32'(stall_cnt), 32'd1);

    do_reset("pre_br");
    set_in(5'd9, 5'd2, 1, 5'd9, 1, 1, 0, 0, 1);
    step("br_lu");
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd0);

    do_reset("pre_wait");
    set_in(5'd1, 5'd2, 0, 5'd3, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("mwait");
    dmem_ready = 1'b1;
    step("mwait_done");
    check("mwait_stall_cnt", 32'(stall_cnt), 32'd3);
    set_in(5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
    step("mwait_run");

    do_reset("pre_to");
    set_in(5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 1, 0);
    for (int i = 0; i < 1 + int'(T); i++) step("tmo");
    check("tmo_err", 32'(mem_err), 32'd1);
    for (int i = 0; i < 2; i++) step("halt");
    check("halt_req", 32'(dmem_req), 32'd0);
    do_reset("post_halt");
    set_in(5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
    step("after_halt");

    set_in(5'd1, 5'd2, 0, 5'd3, 1, 0, 1, 0, 0);
    step("ar_run");
    step("ar_wait");
    do_reset("async_mid_wait");
    set_in(5'd1, 5'd2, 0, 5'd3, 0, 0, 0, 0, 1);
    step("ar_post");

    set_in(5'd4, 5'd7, 1, 5'd7, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step("sat");
    check("sat_stall_cnt", 32'(stall_cnt), 32'(SAT));

    do_reset("pre_rand");
    for (int i = 0; i < 400; i++) begin
      if (m_halt) do_reset("rand_halt");
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_WriteReg = 5'($urandom_range(0, 3));
      ex_MemRead  = 1'($urandom_range(0, 1));
      dmem_ready  = ($urandom_range(0, 3) != 0);
      if (!m_wait) begin
        mem_Branch   = 1'($urandom_range(0, 1));
        mem_zero     = 1'($urandom_range(0, 1));
        mem_MemRead  = ($urandom_range(0, 3) == 0);
        mem_MemWrite = ($urandom_range(0, 3) == 0);
      end
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Resolves three hazard sources:
  - load-use hazards, detected in the ID/EX boundary;
  - taken branches, resolved from the EX/MEM register's Branch and zero outputs;
  - multi-cycle data-memory accesses, via a req/ready handshake.
- Keeps saturating performance counters and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles in MEM_WAIT before the error is declared (legal range 1..65535).
- CNT_W, 16: width of the performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_MemRead  in  1  the instruction in EX is a load.
- ex_WriteReg  in  5  destination register of the instruction in EX.
- mem_Branch  in  1  Branch output of the EX/MEM register.
- mem_zero  in  1  zero output of the EX/MEM register.
- mem_MemRead  in  1  the instruction in MEM is a load.
- mem_MemWrite  in  1  MemWrite output of the EX/MEM register.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory access request.
- pc_en  out  1  PC update enable.
- pc_sel_branch  out  1  select PCBranch as the next PC.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all control bits 0) on the next edge.
- mem_err  out  1  sticky memory timeout.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- flush_cnt  out  CNT_W  taken-branch flush events, saturating.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=RUN;
  - all *_en=0 and all *_flush=1;
  - dmem_req=0, pc_sel_branch=0, mem_err=0;
  - counters=0, internal wait counter=0.
  - Normal operation starts on the first edge after RESET_N rises.
- Definitions used below:
  - memop = mem_MemRead | mem_MemWrite.
  - taken = mem_Branch & mem_zero.
  - lu = ex_MemRead & (ex_WriteReg != 0) & ((ex_WriteReg == id_rs) | (ex_WriteReg == id_rt)).
- FSM states: RUN, MEM_WAIT, HALT.
- Outputs are Moore/Mealy mixed and combinational from the state and the current inputs. The same-cycle dmem_ready path has zero latency.
- RUN, priority from highest to lowest:
  - (a) memop & !dmem_ready:
    - dmem_req=1;
    - pc_en, ifid_en, idex_en and exmem_en all 0;
    - memwb_en=1 with memwb_flush=1 (bubble into WB);
    - next state MEM_WAIT; wait counter=1; stall_cnt+1.
  - (b) taken (memop-free by ISA, or memop with dmem_ready=1):
    - pc_sel_branch=1, pc_en=1;
    - ifid_flush, idex_flush and exmem_flush all 1;
    - all enables 1;
    - flush_cnt+1;
    - lu is ignored.
  - (c) lu:
    - pc_en=0, ifid_en=0;
    - idex_flush=1 (one bubble);
    - exmem and memwb advance;
    - stall_cnt+1;
    - held for exactly one cycle, because the load moves to MEM next cycle and lu deasserts.
  - (d) otherwise: all enables 1, all flushes 0. dmem_req=memop, and in that case dmem_ready is already 1.
- MEM_WAIT:
  - dmem_req=1; pc, ifid, idex and exmem frozen (en=0); memwb bubble each cycle.
  - EX/MEM contents are held stable, so mem_* inputs are constant.
  - If dmem_ready: behave as RUN rule (b)/(c)/(d) this cycle (release all stages) and go to RUN; wait counter cleared.
  - Else: wait counter+1 and stall_cnt+1.
  - When the wait counter reaches MEM_TIMEOUT without dmem_ready: mem_err=1 and go to HALT.
- HALT:
  - All *_en=0, all flushes 0, dmem_req=0.
  - Leaves only via reset.
  - mem_err stays set until reset.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Reset mid-MEM_WAIT aborts the access immediately: dmem_req drops asynchronously.
- The ex_WriteReg==0 case never stalls, because $zero has no real dependency.

Decomposition:
- Shared package (pipe_ctrl_pkg):
  - state enum {RUN, MEM_WAIT, HALT};
  - REG_ZERO=5'd0;
  - default CNT_W.
- One natural sub-module, hazard_sat_counter (parameterised width, inc, async active-low clear), instantiated for stall_cnt and flush_cnt.
- The FSM and hazard detection live in the top module.

Test Plan:
- Load-use: ex_MemRead=1, ex_WriteReg=8, id_rs=8, dmem_ready=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all en=1; stall_cnt=1.
- $zero load: ex_WriteReg=0, id_rt=0, ex_MemRead=1 → no stall, all en=1, stall_cnt unchanged.
- Taken branch together with lu: mem_Branch=1, mem_zero=1, lu true → pc_sel_branch=1, ifid/idex/exmem_flush=1, pc_en=1, flush_cnt=1, stall_cnt=0.
- Memory wait: mem_MemRead=1, dmem_ready low for 3 cycles then high → dmem_req high for 4 cycles; exmem_en=0 for 3 cycles then 1; memwb_flush=1 for 3 cycles; stall_cnt=3; state back to RUN.
- Timeout with MEM_TIMEOUT=4: mem_MemWrite=1, dmem_ready never asserted → mem_err=1 after 4 wait cycles; then all en=0, dmem_req=0 until RESET_N pulse clears mem_err to 0.
- Async reset mid-wait: drop RESET_N between edges while in MEM_WAIT → dmem_req=0 and all flushes=1 immediately; counters=0; first post-reset cycle in RUN.
